axi_txn_limiter: RTL and testbench
==================================

Name: axi_txn_limiter

Overview:
AXI4 full-interface stage placed directly upstream of the emulated RAM model slave port. It passes all AXI channels through and caps outstanding write and read bursts. It holds W beats until their AW has been accepted. It provides a quiesce handshake so the emulation controller can drain in-flight traffic before asserting reset, because the RAM model does not tolerate reset mid-transaction.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 64, AXI data width; strobe width is DATA_WIDTH/8
ID_WIDTH, 4, AXI ID width
MAX_WR, 4, maximum accepted-but-unresponded write bursts (>=1)
MAX_RD, 4, maximum accepted-but-incomplete read bursts (>=1)

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
s_axi_aw{valid,ready,addr,id,len,size,burst,lock,cache,prot,qos,region}  slave AW; widths as AXI4 (addr ADDR_WIDTH, id ID_WIDTH, len 8, size 3, burst 2, lock 1, cache 4, prot 3, qos 4, region 4); ready is out, rest in
s_axi_w{valid,ready,data,strb,last}  slave W; ready out, rest in
s_axi_b{valid,ready,resp,id}  slave B; ready in, rest out
s_axi_ar{...same fields as AW}  slave AR
s_axi_r{valid,ready,data,resp,id,last}  slave R; ready in, rest out
m_axi_*  mirror of every s_axi_* signal with opposite direction, connects to RAM model
quiesce_req  in  1  request drain; level
quiesce_ack  out  1  high while drained and blocked
wr_outstanding  out  $clog2(MAX_WR+1)  current write count
rd_outstanding  out  $clog2(MAX_RD+1)  current read count
proto_err  out  1  sticky underflow error flag

Behaviour:
- All payload fields pass through combinationally. No registers are placed in the data path. Zero added latency.
- Handshake definitions: AW/AR/W handshakes are taken at the m side (m valid & m ready). B/R handshakes are taken at the s side.
- Gating, AW: aw_allow = (state==RUN) & (wr_cnt < MAX_WR). m_awvalid = s_awvalid & aw_allow. s_awready = m_awready & aw_allow. AR is gated identically with rd_cnt and MAX_RD.
- Gating, W: w_allow = (w_credit != 0). m_wvalid = s_wvalid & w_allow. s_wready = m_wready & w_allow. A W beat whose AW is handshaking in the same cycle is still blocked; it passes the next cycle.
- B/R channels are never gated.
- Allow signals depend only on registered state. There is no combinational path from bready, rready or m-side ready into any valid.
- wr_cnt: +1 on AW handshake, -1 on B handshake; unchanged when both occur in the same cycle.
- rd_cnt: +1 on AR handshake, -1 on R handshake with rlast.
- w_credit: +1 on AW handshake, -1 on W handshake with wlast. Its width is the same as wr_cnt.
- At count==MAX, a same-cycle B does not unblock AW; AW resumes the cycle after the count drops.
- Underflow: a B handshake with wr_cnt==0, an R-last handshake with rd_cnt==0, or a wlast with w_credit==0 (impossible by gating) sets proto_err. That counter holds at 0. proto_err clears only on reset.
- FSM states: RUN, DRAIN, IDLE.
  - RUN -> DRAIN when quiesce_req=1.
  - DRAIN -> IDLE when wr_cnt==0 & rd_cnt==0 & w_credit==0, evaluated on next-state counts. With zero outstanding this gives a 1-cycle RUN->DRAIN->IDLE minimum.
  - IDLE -> RUN when quiesce_req=0.
  - DRAIN -> RUN if quiesce_req drops before the drain completes.
  - In DRAIN and IDLE, new AW/AR are blocked; W/B/R continue to flow.
- quiesce_ack = (state==IDLE), registered.
- Reset (aresetn=0 at posedge): state=RUN, all counters 0, proto_err=0, quiesce_ack=0. Combinational outputs follow inputs under the reset-state allow values.
- Reset while transactions are outstanding is outside the contract; the controller must obtain quiesce_ack first.

Decomposition:
- Package axi_txn_limiter_pkg holds:
  - typedef enum logic [1:0] {RUN, DRAIN, IDLE} limiter_state_t;
  - localparams AXI_RESP_OKAY=2'b00 and AXI_BURST_INCR=2'b01 for benches;
  - a count-width function clog2p1(n).
- Sub-module txn_counter (params MAX, W): inc/dec inputs; outputs count, at_max, is_zero, underflow; saturates at 0. It is instantiated three times: wr_cnt, rd_cnt, w_credit.

Test Plan:
- Single-beat write: AW addr 0x100 len 0, W asserted 1 cycle before AW -> W blocked until the cycle after the AW handshake; wr_outstanding 1 -> B OKAY -> 0; proto_err 0.
- MAX_WR=4, issue 5 AWs with bready=0 -> 4 accepted, s_awready=0 on the 5th. Assert bready for one B in the same cycle as the 5th AW is held -> 5th accepted one cycle later.
- Read bursts: 2 ARs len 3, rready toggling 50% -> rd_outstanding goes 2 -> 1 after the first rlast -> 0 after the second. Counts are unchanged on non-last beats.
- Quiesce with 1 read outstanding: quiesce_req=1 -> new AR blocked, R completes, quiesce_ack=1 the cycle after rd_cnt reaches 0. quiesce_req=0 -> ack drops and AR flows the next cycle.
- Quiesce with zero outstanding -> quiesce_ack high 2 cycles after quiesce_req rises. Drop quiesce_req during DRAIN with traffic outstanding -> returns to RUN and ack is never asserted.
- Inject a spurious m_bvalid with wr_cnt=0 and bready=1 -> proto_err=1 and stays set; wr_outstanding stays 0. Reset -> proto_err=0.

Source files
------------

// File: rtl/axi_txn_limiter_pkg.sv
// Shared types and constants for the AXI outstanding-transaction limiter.
package axi_txn_limiter_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, IDLE} limiter_state_t;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Bits needed to hold values 0..n inclusive.
  function automatic int clog2p1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/axi_txn_limiter_counter.sv
// Saturating up/down transaction counter with terminal-value flags.
module txn_counter #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         at_max_o,
  output logic         is_zero_o,
  output logic         underflow_o
);

  logic [W-1:0] count_q, count_d;
  logic         dec_eff;

  assign count_o     = count_q;
  assign at_max_o    = (count_q == W'(MAX));
  assign is_zero_o   = (count_q == '0);
  assign underflow_o = dec_i & is_zero_o;
  // A decrement at zero is reported as underflow and otherwise ignored.
  assign dec_eff     = dec_i & ~is_zero_o;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_eff && !at_max_o) begin
      count_d = count_q + 1'b1;
    end else if (dec_eff && !inc_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/axi_txn_limiter.sv
// AXI4 pass-through that caps outstanding bursts, holds W until its AW is
// accepted, and offers a quiesce handshake for draining before reset.
module axi_txn_limiter
  import axi_txn_limiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int MAX_WR     = 4,
  parameter int MAX_RD     = 4
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
  input  logic [ID_WIDTH-1:0]          s_axi_awid,
  input  logic [7:0]                   s_axi_awlen,
  input  logic [2:0]                   s_axi_awsize,
  input  logic [1:0]                   s_axi_awburst,
  input  logic                         s_axi_awlock,
  input  logic [3:0]                   s_axi_awcache,
  input  logic [2:0]                   s_axi_awprot,
  input  logic [3:0]                   s_axi_awqos,
  input  logic [3:0]                   s_axi_awregion,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  input  logic [DATA_WIDTH-1:0]        s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]      s_axi_wstrb,
  input  logic                         s_axi_wlast,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  output logic [1:0]                   s_axi_bresp,
  output logic [ID_WIDTH-1:0]          s_axi_bid,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic [ID_WIDTH-1:0]          s_axi_arid,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  input  logic                         s_axi_arlock,
  input  logic [3:0]                   s_axi_arcache,
  input  logic [2:0]                   s_axi_arprot,
  input  logic [3:0]                   s_axi_arqos,
  input  logic [3:0]                   s_axi_arregion,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [DATA_WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic [ID_WIDTH-1:0]          s_axi_rid,
  output logic                         s_axi_rlast,
  output logic                         m_axi_awvalid,
  input  logic                         m_axi_awready,
  output logic [ADDR_WIDTH-1:0]        m_axi_awaddr,
  output logic [ID_WIDTH-1:0]          m_axi_awid,
  output logic [7:0]                   m_axi_awlen,
  output logic [2:0]                   m_axi_awsize,
  output logic [1:0]                   m_axi_awburst,
  output logic                         m_axi_awlock,
  output logic [3:0]                   m_axi_awcache,
  output logic [2:0]                   m_axi_awprot,
  output logic [3:0]                   m_axi_awqos,
  output logic [3:0]                   m_axi_awregion,
  output logic                         m_axi_wvalid,
  input  logic                         m_axi_wready,
  output logic [DATA_WIDTH-1:0]        m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]      m_axi_wstrb,
  output logic                         m_axi_wlast,
  input  logic                         m_axi_bvalid,
  output logic                         m_axi_bready,
  input  logic [1:0]                   m_axi_bresp,
  input  logic [ID_WIDTH-1:0]          m_axi_bid,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  output logic [ADDR_WIDTH-1:0]        m_axi_araddr,
  output logic [ID_WIDTH-1:0]          m_axi_arid,
  output logic [7:0]                   m_axi_arlen,
  output logic [2:0]                   m_axi_arsize,
  output logic [1:0]                   m_axi_arburst,
  output logic                         m_axi_arlock,
  output logic [3:0]                   m_axi_arcache,
  output logic [2:0]                   m_axi_arprot,
  output logic [3:0]                   m_axi_arqos,
  output logic [3:0]                   m_axi_arregion,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready,
  input  logic [DATA_WIDTH-1:0]        m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp,
  input  logic [ID_WIDTH-1:0]          m_axi_rid,
  input  logic                         m_axi_rlast,
  input  logic                         quiesce_req,
  output logic                         quiesce_ack,
  output logic [$clog2(MAX_WR+1)-1:0]  wr_outstanding,
  output logic [$clog2(MAX_RD+1)-1:0]  rd_outstanding,
  output logic                         proto_err
);

  localparam int WR_W = clog2p1(MAX_WR);
  localparam int RD_W = clog2p1(MAX_RD);

  limiter_state_t  state_q;
  logic            quiesce_ack_q, proto_err_q;
  logic [WR_W-1:0] wr_cnt, wc_cnt;
  logic [RD_W-1:0] rd_cnt;
  logic            wr_at_max, wr_zero, wr_unf;
  logic            wc_at_max, wc_zero, wc_unf;
  logic            rd_at_max, rd_zero, rd_unf;
  logic            aw_allow, ar_allow, w_allow;
  logic            aw_hs, ar_hs, wl_hs, b_hs, rl_hs;
  logic            drained_next;

  // wc_at_max is redundant for legal traffic (credit never exceeds wr_cnt)
  // but keeps the credit counter from saturating if a slave responds early.
  assign aw_allow = (state_q == RUN) & ~wr_at_max & ~wc_at_max;
  assign ar_allow = (state_q == RUN) & ~rd_at_max;
  assign w_allow  = ~wc_zero;

  assign m_axi_awvalid  = s_axi_awvalid & aw_allow;
  assign s_axi_awready  = m_axi_awready & aw_allow;
  assign m_axi_awaddr   = s_axi_awaddr;
  assign m_axi_awid     = s_axi_awid;
  assign m_axi_awlen    = s_axi_awlen;
  assign m_axi_awsize   = s_axi_awsize;
  assign m_axi_awburst  = s_axi_awburst;
  assign m_axi_awlock   = s_axi_awlock;
  assign m_axi_awcache  = s_axi_awcache;
  assign m_axi_awprot   = s_axi_awprot;
  assign m_axi_awqos    = s_axi_awqos;
  assign m_axi_awregion = s_axi_awregion;

  assign m_axi_wvalid   = s_axi_wvalid & w_allow;
  assign s_axi_wready   = m_axi_wready & w_allow;
  assign m_axi_wdata    = s_axi_wdata;
  assign m_axi_wstrb    = s_axi_wstrb;
  assign m_axi_wlast    = s_axi_wlast;

  assign s_axi_bvalid   = m_axi_bvalid;
  assign m_axi_bready   = s_axi_bready;
  assign s_axi_bresp    = m_axi_bresp;
  assign s_axi_bid      = m_axi_bid;

  assign m_axi_arvalid  = s_axi_arvalid & ar_allow;
  assign s_axi_arready  = m_axi_arready & ar_allow;
  assign m_axi_araddr   = s_axi_araddr;
  assign m_axi_arid     = s_axi_arid;
  assign m_axi_arlen    = s_axi_arlen;
  assign m_axi_arsize   = s_axi_arsize;
  assign m_axi_arburst  = s_axi_arburst;
  assign m_axi_arlock   = s_axi_arlock;
  assign m_axi_arcache  = s_axi_arcache;
  assign m_axi_arprot   = s_axi_arprot;
  assign m_axi_arqos    = s_axi_arqos;
  assign m_axi_arregion = s_axi_arregion;

  assign s_axi_rvalid   = m_axi_rvalid;
  assign m_axi_rready   = s_axi_rready;
  assign s_axi_rdata    = m_axi_rdata;
  assign s_axi_rresp    = m_axi_rresp;
  assign s_axi_rid      = m_axi_rid;
  assign s_axi_rlast    = m_axi_rlast;

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign ar_hs = m_axi_arvalid & m_axi_arready;
  assign wl_hs = m_axi_wvalid & m_axi_wready & m_axi_wlast;
  assign b_hs  = m_axi_bvalid & s_axi_bready;
  assign rl_hs = m_axi_rvalid & s_axi_rready & m_axi_rlast;

  txn_counter #(.MAX(MAX_WR), .W(WR_W)) u_wr_cnt (
    .clk_i(aclk), .rst_n_i(aresetn), .inc_i(aw_hs), .dec_i(b_hs),
    .count_o(wr_cnt), .at_max_o(wr_at_max), .is_zero_o(wr_zero), .underflow_o(wr_unf)
  );

  txn_counter #(.MAX(MAX_RD), .W(RD_W)) u_rd_cnt (
    .clk_i(aclk), .rst_n_i(aresetn), .inc_i(ar_hs), .dec_i(rl_hs),
    .count_o(rd_cnt), .at_max_o(rd_at_max), .is_zero_o(rd_zero), .underflow_o(rd_unf)
  );

  txn_counter #(.MAX(MAX_WR), .W(WR_W)) u_w_credit (
    .clk_i(aclk), .rst_n_i(aresetn), .inc_i(aw_hs), .dec_i(wl_hs),
    .count_o(wc_cnt), .at_max_o(wc_at_max), .is_zero_o(wc_zero), .underflow_o(wc_unf)
  );

  // Only consulted in DRAIN, where AW/AR are blocked, so no increments occur.
  assign drained_next = (wr_zero | ((wr_cnt == WR_W'(1)) & b_hs))
                      & (rd_zero | ((rd_cnt == RD_W'(1)) & rl_hs))
                      & (wc_zero | ((wc_cnt == WR_W'(1)) & wl_hs));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= RUN;
      quiesce_ack_q <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      if (wr_unf || rd_unf || wc_unf) begin
        proto_err_q <= 1'b1;
      end
      case (state_q)
        RUN: begin
          if (quiesce_req) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!quiesce_req) begin
            state_q <= RUN;
          end else if (drained_next) begin
            state_q       <= IDLE;
            quiesce_ack_q <= 1'b1;
          end
        end
        IDLE: begin
          if (!quiesce_req) begin
            state_q       <= RUN;
            quiesce_ack_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= RUN;
          quiesce_ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign quiesce_ack    = quiesce_ack_q;
  assign proto_err      = proto_err_q;
  assign wr_outstanding = wr_cnt;
  assign rd_outstanding = rd_cnt;

endmodule

// File: tb/tb_axi_txn_limiter.sv
// Self-checking bench for axi_txn_limiter: vector table, directed corner
// sequences and randomized traffic against a counting reference model.
module tb_axi_txn_limiter;
  import axi_txn_limiter_pkg::AXI_RESP_OKAY;
  import axi_txn_limiter_pkg::AXI_BURST_INCR;

  localparam int AW = 32, DW = 64, IW = 4, MAX_WR = 4, MAX_RD = 4;

  logic aclk = 1'b0, aresetn;
  logic s_axi_awvalid, s_axi_awready, s_axi_awlock;
  logic [AW-1:0] s_axi_awaddr;  logic [IW-1:0] s_axi_awid;  logic [7:0] s_axi_awlen;
  logic [2:0] s_axi_awsize, s_axi_awprot;  logic [1:0] s_axi_awburst;
  logic [3:0] s_axi_awcache, s_axi_awqos, s_axi_awregion;
  logic s_axi_wvalid, s_axi_wready, s_axi_wlast;
  logic [DW-1:0] s_axi_wdata;  logic [DW/8-1:0] s_axi_wstrb;
  logic s_axi_bvalid, s_axi_bready;  logic [1:0] s_axi_bresp;  logic [IW-1:0] s_axi_bid;
  logic s_axi_arvalid, s_axi_arready, s_axi_arlock;
  logic [AW-1:0] s_axi_araddr;  logic [IW-1:0] s_axi_arid;  logic [7:0] s_axi_arlen;
  logic [2:0] s_axi_arsize, s_axi_arprot;  logic [1:0] s_axi_arburst;
  logic [3:0] s_axi_arcache, s_axi_arqos, s_axi_arregion;
  logic s_axi_rvalid, s_axi_rready, s_axi_rlast;
  logic [DW-1:0] s_axi_rdata;  logic [1:0] s_axi_rresp;  logic [IW-1:0] s_axi_rid;
  logic m_axi_awvalid, m_axi_awready, m_axi_awlock;
  logic [AW-1:0] m_axi_awaddr;  logic [IW-1:0] m_axi_awid;  logic [7:0] m_axi_awlen;
  logic [2:0] m_axi_awsize, m_axi_awprot;  logic [1:0] m_axi_awburst;
  logic [3:0] m_axi_awcache, m_axi_awqos, m_axi_awregion;
  logic m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [DW-1:0] m_axi_wdata;  logic [DW/8-1:0] m_axi_wstrb;
  logic m_axi_bvalid, m_axi_bready;  logic [1:0] m_axi_bresp;  logic [IW-1:0] m_axi_bid;
  logic m_axi_arvalid, m_axi_arready, m_axi_arlock;
  logic [AW-1:0] m_axi_araddr;  logic [IW-1:0] m_axi_arid;  logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize, m_axi_arprot;  logic [1:0] m_axi_arburst;
  logic [3:0] m_axi_arcache, m_axi_arqos, m_axi_arregion;
  logic m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [DW-1:0] m_axi_rdata;  logic [1:0] m_axi_rresp;  logic [IW-1:0] m_axi_rid;
  logic quiesce_req, quiesce_ack, proto_err;
  logic [2:0] wr_outstanding, rd_outstanding;

  axi_txn_limiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock), .s_axi_awcache(s_axi_awcache),
    .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos), .s_axi_awregion(s_axi_awregion),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp), .s_axi_bid(s_axi_bid),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock), .s_axi_arcache(s_axi_arcache),
    .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos), .s_axi_arregion(s_axi_arregion),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rid(s_axi_rid), .s_axi_rlast(s_axi_rlast),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
    .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos), .m_axi_awregion(m_axi_awregion),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp), .m_axi_bid(m_axi_bid),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
    .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos), .m_axi_arregion(m_axi_arregion),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rid(m_axi_rid), .m_axi_rlast(m_axi_rlast),
    .quiesce_req(quiesce_req), .quiesce_ack(quiesce_ack),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding), .proto_err(proto_err)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding bursts as plain integers plus a quiesce mode.
  typedef enum {M_RUN, M_DRAIN, M_IDLE} ref_mode_t;
  ref_mode_t ref_st;
  int ref_wr, ref_rd, ref_cred;
  bit ref_perr;

  task automatic model_reset();
    ref_st = M_RUN; ref_wr = 0; ref_rd = 0; ref_cred = 0; ref_perr = 0;
  endtask

  function automatic bit aw_ok(); return ref_st == M_RUN && ref_wr < MAX_WR; endfunction
  function automatic bit ar_ok(); return ref_st == M_RUN && ref_rd < MAX_RD; endfunction
  function automatic bit w_ok();  return ref_cred != 0; endfunction

  task automatic check_model();
    chk("m_awvalid", 128'(m_axi_awvalid), 128'(s_axi_awvalid & aw_ok()));
    chk("s_awready", 128'(s_axi_awready), 128'(m_axi_awready & aw_ok()));
    chk("m_arvalid", 128'(m_axi_arvalid), 128'(s_axi_arvalid & ar_ok()));
    chk("s_arready", 128'(s_axi_arready), 128'(m_axi_arready & ar_ok()));
    chk("m_wvalid",  128'(m_axi_wvalid),  128'(s_axi_wvalid & w_ok()));
    chk("s_wready",  128'(s_axi_wready),  128'(m_axi_wready & w_ok()));
    chk("wr_outstanding", 128'(wr_outstanding), 128'(ref_wr));
    chk("rd_outstanding", 128'(rd_outstanding), 128'(ref_rd));
    chk("quiesce_ack", 128'(quiesce_ack), 128'(ref_st == M_IDLE));
    chk("proto_err", 128'(proto_err), 128'(ref_perr));
    chk("aw_pass", {m_axi_awaddr, m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst,
                    m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion},
                   {s_axi_awaddr, s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awburst,
                    s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion});
    chk("ar_pass", {m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst,
                    m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion},
                   {s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arsize, s_axi_arburst,
                    s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion});
    chk("w_pass", {m_axi_wdata, m_axi_wstrb, m_axi_wlast}, {s_axi_wdata, s_axi_wstrb, s_axi_wlast});
    chk("b_pass", {s_axi_bvalid, m_axi_bready, s_axi_bresp, s_axi_bid},
                  {m_axi_bvalid, s_axi_bready, m_axi_bresp, m_axi_bid});
    chk("r_pass", {s_axi_rvalid, m_axi_rready, s_axi_rdata, s_axi_rresp, s_axi_rid, s_axi_rlast},
                  {m_axi_rvalid, s_axi_rready, m_axi_rdata, m_axi_rresp, m_axi_rid, m_axi_rlast});
  endtask

  task automatic model_step();
    bit aw_hs, ar_hs, wl_hs, b_hs, rl_hs;
    aw_hs = s_axi_awvalid && m_axi_awready && aw_ok();
    ar_hs = s_axi_arvalid && m_axi_arready && ar_ok();
    wl_hs = s_axi_wvalid && s_axi_wlast && m_axi_wready && w_ok();
    b_hs  = m_axi_bvalid && s_axi_bready;
    rl_hs = m_axi_rvalid && m_axi_rlast && s_axi_rready;
    if ((b_hs && ref_wr == 0) || (rl_hs && ref_rd == 0) || (wl_hs && ref_cred == 0)) ref_perr = 1;
    ref_wr   = ref_wr   + (aw_hs ? 1 : 0) - ((b_hs  && ref_wr   > 0) ? 1 : 0);
    ref_rd   = ref_rd   + (ar_hs ? 1 : 0) - ((rl_hs && ref_rd   > 0) ? 1 : 0);
    ref_cred = ref_cred + (aw_hs ? 1 : 0) - ((wl_hs && ref_cred > 0) ? 1 : 0);
    case (ref_st)
      M_RUN:   if (quiesce_req) ref_st = M_DRAIN;
      M_DRAIN: if (!quiesce_req) ref_st = M_RUN;
               else if (ref_wr == 0 && ref_rd == 0 && ref_cred == 0) ref_st = M_IDLE;
      M_IDLE:  if (!quiesce_req) ref_st = M_RUN;
      default: ref_st = M_RUN;
    endcase
  endtask

  // Inputs change 1 time unit after posedge; outputs are checked on negedge.
  task automatic tick();
    @(negedge aclk);
    check_model();
    model_step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    s_axi_awvalid = 0; m_axi_awready = 0; s_axi_wvalid = 0; s_axi_wlast = 0; m_axi_wready = 0;
    m_axi_bvalid = 0; s_axi_bready = 0; s_axi_arvalid = 0; m_axi_arready = 0;
    m_axi_rvalid = 0; m_axi_rlast = 0; s_axi_rready = 0; quiesce_req = 0;
  endtask

  task automatic rand_payload();
    s_axi_awaddr = $urandom; s_axi_awid = 4'($urandom); s_axi_awlen = 8'($urandom);
    s_axi_awsize = 3'($urandom); s_axi_awburst = AXI_BURST_INCR; s_axi_awlock = 1'($urandom);
    s_axi_awcache = 4'($urandom); s_axi_awprot = 3'($urandom); s_axi_awqos = 4'($urandom);
    s_axi_awregion = 4'($urandom);
    s_axi_araddr = $urandom; s_axi_arid = 4'($urandom); s_axi_arlen = 8'($urandom);
    s_axi_arsize = 3'($urandom); s_axi_arburst = 2'($urandom); s_axi_arlock = 1'($urandom);
    s_axi_arcache = 4'($urandom); s_axi_arprot = 3'($urandom); s_axi_arqos = 4'($urandom);
    s_axi_arregion = 4'($urandom);
    s_axi_wdata = {$urandom, $urandom}; s_axi_wstrb = 8'($urandom);
    m_axi_bresp = 2'($urandom); m_axi_bid = 4'($urandom);
    m_axi_rdata = {$urandom, $urandom}; m_axi_rresp = 2'($urandom); m_axi_rid = 4'($urandom);
  endtask

  task automatic do_reset();
    idle_inputs();
    aresetn = 0;
    @(posedge aclk);
    #1;
    aresetn = 1;
    model_reset();
  endtask

  typedef struct {
    logic awv, awr, wv, wl, wr, bv, br;
    logic e_awrdy, e_mawv, e_wrdy, e_mwv;
    int   e_wr;
  } vec_t;

  function automatic vec_t mk(logic awv, logic awr, logic wv, logic wl, logic wr, logic bv,
                              logic br, logic e_awrdy, logic e_mawv, logic e_wrdy,
                              logic e_mwv, int e_wr);
    vec_t v;
    v.awv = awv; v.awr = awr; v.wv = wv; v.wl = wl; v.wr = wr; v.bv = bv; v.br = br;
    v.e_awrdy = e_awrdy; v.e_mawv = e_mawv; v.e_wrdy = e_wrdy; v.e_mwv = e_mwv; v.e_wr = e_wr;
    return v;
  endfunction

  vec_t tbl[13];
  int beats, cyc;
  bit rhs;

  initial begin
    //           awv awr wv wl wr bv br | awrdy mawv wrdy mwv wr_cnt
    tbl[0]  = mk(0, 0, 1, 1, 1, 0, 0,   0, 0, 0, 0, 0); // W before AW: held
    tbl[1]  = mk(1, 1, 1, 1, 1, 0, 0,   1, 1, 0, 0, 0); // AW accepted, W still held
    tbl[2]  = mk(0, 0, 1, 1, 1, 0, 0,   0, 0, 1, 1, 1); // W passes next cycle
    tbl[3]  = mk(0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 1); // B OKAY
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0); // four AWs, bready low
    tbl[6]  = mk(1, 1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1);
    tbl[7]  = mk(1, 1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 2);
    tbl[8]  = mk(1, 1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 3);
    tbl[9]  = mk(1, 1, 1, 1, 1, 0, 0,   0, 0, 1, 1, 4); // 5th AW held at MAX
    tbl[10] = mk(1, 1, 0, 0, 0, 1, 1,   0, 0, 0, 0, 4); // same-cycle B does not unblock
    tbl[11] = mk(1, 1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 3); // 5th AW accepted next cycle
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 4);

    model_reset();
    idle_inputs();
    rand_payload();
    m_axi_bresp = AXI_RESP_OKAY;
    aresetn = 0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1;
    chk("rst_wr", 128'(wr_outstanding), 128'(0));
    chk("rst_rd", 128'(rd_outstanding), 128'(0));
    chk("rst_ack", 128'(quiesce_ack), 128'(0));
    chk("rst_perr", 128'(proto_err), 128'(0));

    s_axi_awaddr = 32'h100; s_axi_awlen = 8'd0;
    for (int i = 0; i < 13; i++) begin
      s_axi_awvalid = tbl[i].awv; m_axi_awready = tbl[i].awr; s_axi_wvalid = tbl[i].wv;
      s_axi_wlast = tbl[i].wl; m_axi_wready = tbl[i].wr; m_axi_bvalid = tbl[i].bv;
      s_axi_bready = tbl[i].br;
      #1;
      chk($sformatf("tbl%0d_s_awready", i), 128'(s_axi_awready), 128'(tbl[i].e_awrdy));
      chk($sformatf("tbl%0d_m_awvalid", i), 128'(m_axi_awvalid), 128'(tbl[i].e_mawv));
      chk($sformatf("tbl%0d_s_wready", i),  128'(s_axi_wready),  128'(tbl[i].e_wrdy));
      chk($sformatf("tbl%0d_m_wvalid", i),  128'(m_axi_wvalid),  128'(tbl[i].e_mwv));
      chk($sformatf("tbl%0d_wr_cnt", i),    128'(wr_outstanding), 128'(tbl[i].e_wr));
      chk($sformatf("tbl%0d_perr", i),      128'(proto_err), 128'(0));
      tick();
    end

    // Two len-3 reads, rready toggling; count drops only on rlast.
    do_reset();
    s_axi_arvalid = 1; m_axi_arready = 1; s_axi_arlen = 8'd3;
    tick(); tick();
    s_axi_arvalid = 0;
    chk("rd_two_issued", 128'(rd_outstanding), 128'(2));
    beats = 0;
    m_axi_rvalid = 1;
    for (cyc = 0; cyc < 40 && beats < 8; cyc++) begin
      s_axi_rready = cyc[0];
      m_axi_rlast  = (beats % 4 == 3);
      rhs = s_axi_rready;
      tick();
      if (rhs) beats++;
      chk("rd_burst_count", 128'(rd_outstanding), 128'(2 - beats / 4));
    end
    chk("rd_beats_done", 128'(beats), 128'(8));
    idle_inputs();

    // Quiesce with one read outstanding.
    do_reset();
    s_axi_arvalid = 1; m_axi_arready = 1;
    tick();
    s_axi_arvalid = 0; quiesce_req = 1;
    tick();
    s_axi_arvalid = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ar_blocked_drain", 128'(m_axi_arvalid), 128'(0));
      chk("ack_low_drain", 128'(quiesce_ack), 128'(0));
      tick();
    end
    m_axi_rvalid = 1; s_axi_rready = 1; m_axi_rlast = 1;
    tick();
    m_axi_rvalid = 0; s_axi_rready = 0; m_axi_rlast = 0;
    chk("ack_after_drain", 128'(quiesce_ack), 128'(1));
    chk("rd_after_drain", 128'(rd_outstanding), 128'(0));
    #1;
    chk("ar_blocked_idle", 128'(m_axi_arvalid), 128'(0));
    tick();
    quiesce_req = 0;
    tick();
    chk("ack_drop", 128'(quiesce_ack), 128'(0));
    #1;
    chk("ar_resume", 128'(m_axi_arvalid), 128'(1));
    tick();
    idle_inputs();

    // Quiesce with nothing outstanding: ack two cycles after the request.
    do_reset();
    quiesce_req = 1;
    tick();
    chk("ack_idle_c1", 128'(quiesce_ack), 128'(0));
    tick();
    chk("ack_idle_c2", 128'(quiesce_ack), 128'(1));
    quiesce_req = 0;
    tick();
    chk("ack_idle_release", 128'(quiesce_ack), 128'(0));

    // Abort a drain while a write is outstanding.
    s_axi_awvalid = 1; m_axi_awready = 1;
    tick();
    s_axi_awvalid = 0; quiesce_req = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ack_abort_low", 128'(quiesce_ack), 128'(0));
    end
    quiesce_req = 0;
    tick();
    chk("ack_abort_after", 128'(quiesce_ack), 128'(0));
    s_axi_awvalid = 1;
    #1;
    chk("aw_after_abort", 128'(m_axi_awvalid), 128'(1));
    tick();
    idle_inputs();

    // Spurious B with nothing outstanding.
    do_reset();
    m_axi_bvalid = 1; s_axi_bready = 1;
    tick();
    m_axi_bvalid = 0; s_axi_bready = 0;
    chk("perr_set", 128'(proto_err), 128'(1));
    chk("perr_wr_zero", 128'(wr_outstanding), 128'(0));
    repeat (3) tick();
    chk("perr_sticky", 128'(proto_err), 128'(1));
    do_reset();
    chk("perr_reset", 128'(proto_err), 128'(0));

    // Randomized legal traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_payload();
      s_axi_awvalid = 1'($urandom); m_axi_awready = 1'($urandom);
      s_axi_wvalid  = 1'($urandom); s_axi_wlast   = 1'($urandom); m_axi_wready = 1'($urandom);
      s_axi_arvalid = 1'($urandom); m_axi_arready = 1'($urandom);
      m_axi_bvalid  = (ref_wr > ref_cred) ? 1'($urandom) : 1'b0;
      s_axi_bready  = 1'($urandom);
      m_axi_rvalid  = (ref_rd > 0) ? 1'($urandom) : 1'b0;
      m_axi_rlast   = ($urandom_range(0, 3) == 0);
      s_axi_rready  = 1'($urandom);
      if ($urandom_range(0, 29) == 0) quiesce_req = ~quiesce_req;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
